simple_bus: RTL and testbench

Two-master / two-slave shared bus with a fixed-handover arbiter, an address decoder and a read-data return path. Masters M0 and M1 request the bus. The granted master's address, write enable and write data are routed to both slaves. One slave select is asserted from the address, and the selected slave's read data is returned to the masters one cycle later. It sits between two bus masters (for example, a CPU and a DMA engine) and two memory-mapped slaves (for example, RAMs).

---
 rtl/simple_bus.sv | 94 +++++++++
 tb/tb_simple_bus.sv | 128 ++++++++++++
 2 files changed

// File: rtl/simple_bus.sv
// Two-master / two-slave shared bus: request arbiter, address decoder and a
// registered read-data return path from the selected slave.
module simple_bus (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [7:0]  m0_address,
  input  logic [31:0] m0_dout,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [7:0]  m1_address,
  input  logic [31:0] m1_dout,
  input  logic [31:0] s0_dout,
  input  logic [31:0] s1_dout,
  output logic        m0_grant,
  output logic        m1_grant,
  output logic [31:0] m_din,
  output logic        s0_sel,
  output logic        s1_sel,
  output logic [7:0]  s_address,
  output logic        s_wr,
  output logic [31:0] s_din
);

  localparam int unsigned AddrW = 8;
  localparam int unsigned DataW = 32;
  localparam int unsigned SelW  = 2;

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SelW-1:0]     sel_q, sel_d;

  // State and read-return select registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= M0_GRANT;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Owner keeps the bus until it drops req while the other master requests
  always_comb begin
    state_d = state_q;
    case (state_q)
      M0_GRANT: if (!m0_req && m1_req) state_d = M1_GRANT;
      M1_GRANT: if (!m1_req && m0_req) state_d = M0_GRANT;
      default:  state_d = M0_GRANT;
    endcase
  end

  // Grants, master mux, decoder and read-data select
  always_comb begin
    m0_grant  = 1'b0;
    m1_grant  = 1'b0;
    s_address = m0_address;
    s_wr      = m0_wr;
    s_din     = m0_dout;
    s0_sel    = 1'b0;
    s1_sel    = 1'b0;
    m_din     = '0;

    if (state_q == M1_GRANT) begin
      m1_grant  = 1'b1;
      s_address = m1_address;
      s_wr      = m1_wr;
      s_din     = m1_dout;
    end else begin
      m0_grant  = 1'b1;
    end

    // 0x00-0x1F slave 0, 0x20-0x3F slave 1, the rest unmapped
    if (s_address[AddrW-1:6] == '0) begin
      s0_sel = ~s_address[5];
      s1_sel =  s_address[5];
    end

    sel_d = {s0_sel, s1_sel};

    case (sel_q)
      2'b10:   m_din = s0_dout;
      2'b01:   m_din = s1_dout;
      default: m_din = DataW'(0);
    endcase
  end

endmodule

// File: tb/tb_simple_bus.sv
// Randomised self-checking bench for simple_bus against a behavioural model
// of ownership, address map and one-cycle read return.
module tb_simple_bus;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [7:0]  m0_address, m1_address;
  logic [31:0] m0_dout, m1_dout, s0_dout, s1_dout;
  logic        m0_grant, m1_grant, s0_sel, s1_sel, s_wr;
  logic [31:0] m_din, s_din;
  logic [7:0]  s_address;

  int checks = 0;
  int errors = 0;

  // Model: current owner (0/1) and slave targeted in the previous cycle (-1 none)
  int owner = 0;
  int prev_tgt = -1;

  always #5 clk = ~clk;

  simple_bus dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
    .s0_dout(s0_dout), .s1_dout(s1_dout),
    .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
    .s0_sel(s0_sel), .s1_sel(s1_sel),
    .s_address(s_address), .s_wr(s_wr), .s_din(s_din)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int target(input logic [7:0] a);
    if (a < 8'd32) return 0;
    if (a < 8'd64) return 1;
    return -1;
  endfunction

  // Drive one cycle after the falling edge, check outputs, then advance the model
  task automatic step(input logic rst,
                      input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                      input logic [31:0] sd0, input logic [31:0] sd1);
    logic [7:0]  ea;
    logic        ew;
    logic [31:0] ed, emd;
    int          t;
    @(negedge clk);
    reset = rst;
    m0_req = r0; m0_wr = w0; m0_address = a0; m0_dout = d0;
    m1_req = r1; m1_wr = w1; m1_address = a1; m1_dout = d1;
    s0_dout = sd0; s1_dout = sd1;
    #1;
    ea = (owner == 1) ? a1 : a0;
    ew = (owner == 1) ? w1 : w0;
    ed = (owner == 1) ? d1 : d0;
    t  = target(ea);
    emd = (prev_tgt == 0) ? sd0 : (prev_tgt == 1) ? sd1 : 32'h0;
    check("m0_grant", 32'(m0_grant), 32'(owner == 0));
    check("m1_grant", 32'(m1_grant), 32'(owner == 1));
    check("s_address", 32'(s_address), 32'(ea));
    check("s_wr", 32'(s_wr), 32'(ew));
    check("s_din", s_din, ed);
    check("s0_sel", 32'(s0_sel), 32'(t == 0));
    check("s1_sel", 32'(s1_sel), 32'(t == 1));
    check("m_din", m_din, emd);
    @(posedge clk);
    if (rst) begin
      owner = 0;
      prev_tgt = -1;
    end else begin
      prev_tgt = t;
      if (owner == 0 && !r0 && r1) owner = 1;
      else if (owner == 1 && !r1 && r0) owner = 0;
    end
  endtask

  initial begin
    reset = 1'b1;
    m0_req = 0; m0_wr = 0; m0_address = 0; m0_dout = 0;
    m1_req = 0; m1_wr = 0; m1_address = 0; m1_dout = 0;
    s0_dout = 0; s1_dout = 0;
    @(posedge clk);
    // Reset with idle inputs
    step(1, 0,0,8'h00,0, 0,0,8'h00,0, 0,0);
    step(0, 0,0,8'h00,0, 0,0,8'h00,0, 0,0);
    // M0 writes to slave 0
    for (int i = 1; i <= 3; i++)
      step(0, 1,1,8'(i),32'(2*i), 0,0,8'h00,0, 1,2);
    // M0 writes to slave 1 while M1 also requests
    for (int i = 0; i < 3; i++)
      step(0, 1,1,8'(8'h20+i),32'(8'h20+2*i), 1,0,8'h00,0, 1,2);
    // M0 out of range
    step(0, 1,1,8'hA0,32'h55, 1,0,8'h00,0, 1,2);
    step(0, 1,0,8'hA0,32'h55, 1,0,8'h00,0, 1,2);
    // Handover to M1, then M1 traffic to both slaves with M0 requesting again
    step(0, 0,0,8'h00,0, 1,0,8'h05,0, 7,8);
    for (int i = 5; i <= 7; i++)
      step(0, 1,0,8'h00,0, 1,0,8'(i),32'(i), 7,8);
    for (int i = 5; i <= 7; i++)
      step(0, 1,0,8'h00,0, 1,1,8'(8'h20+i),32'(i), 7,8);
    // M1 out of range, then idle hold
    step(0, 0,0,8'h00,0, 1,0,8'hA0,0, 7,8);
    step(0, 0,0,8'h00,0, 0,0,8'hA0,0, 7,8);
    step(0, 0,0,8'h00,0, 0,0,8'h01,0, 7,8);
    step(0, 0,0,8'h00,0, 0,0,8'h01,0, 7,8);
    // Mid-transfer reset returns the bus to M0
    step(1, 0,0,8'h21,0, 1,1,8'h01,0, 7,8);
    step(0, 0,0,8'h21,0, 1,1,8'h01,0, 7,8);
    // Randomised traffic with occasional reset
    for (int n = 0; n < 400; n++)
      step(($urandom_range(0, 39) == 0),
           1'($urandom), 1'($urandom), 8'($urandom_range(0, 95)), $urandom,
           1'($urandom), 1'($urandom), 8'($urandom_range(0, 95)), $urandom,
           $urandom, $urandom);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
